operand_stage: RTL



---
 rtl/alu_defs.sv | 56 +++++
 rtl/regfile.sv | 40 ++++
 rtl/operand_stage.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/alu_defs.sv
// Shared decode constants: ALU operation codes and the RV32I opcode/funct fields
// needed by the operand stage (the ALU uses the same op-code enum).
package alu_defs;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic    legal;
    logic    use_imm;
    logic    imm_is_shamt;
    alu_op_e op;
  } decode_t;

  // Operation selected by funct3 when funct7 is the base (all-zero) pattern.
  function automatic alu_op_e base_op(input logic [2:0] f3);
    alu_op_e op;
    case (f3)
      F3_ADD_SUB: op = ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/regfile.sv
// 32 x XLEN register file: two combinational read ports, one synchronous write
// port, x0 hardwired to zero, write-through bypass on reads.
module regfile
  import alu_defs::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic [4:0]      i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [4:0]      i_raddr_a,
  input  logic [4:0]      i_raddr_b,
  output logic [XLEN-1:0] o_rdata_a,
  output logic [XLEN-1:0] o_rdata_b
);

  logic [XLEN-1:0] r_mem [32];
  logic            w_hit_a;
  logic            w_hit_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // A write landing this cycle is forwarded so the reader sees the new value.
  assign w_hit_a = i_we && (i_waddr == i_raddr_a);
  assign w_hit_b = i_we && (i_waddr == i_raddr_b);

  assign o_rdata_a = (i_raddr_a == 5'd0) ? '0 : (w_hit_a ? i_wdata : r_mem[i_raddr_a]);
  assign o_rdata_b = (i_raddr_b == 5'd0) ? '0 : (w_hit_b ? i_wdata : r_mem[i_raddr_b]);

endmodule

// File: rtl/operand_stage.sv
// Decode/operand-fetch stage: decodes RV32I R/I-type ALU instructions, reads
// rs1/rs2 with writeback bypass and holds the ALU operands in one output slot.
module operand_stage
  import alu_defs::*;
#(
  parameter int XLEN = 32,
  parameter int OPW  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [OPW-1:0]  out_op,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            illegal
);

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_imm_sext;
  logic [XLEN-1:0] w_imm_shamt;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic [XLEN-1:0] w_b_sel;
  logic            w_accept;
  decode_t         w_dec;

  logic            r_valid;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  alu_op_e         r_op;
  logic [4:0]      r_rd;
  logic            r_we;
  logic            r_illegal;

  assign w_opcode    = in_instr[6:0];
  assign w_rd        = in_instr[11:7];
  assign w_funct3    = in_instr[14:12];
  assign w_rs1       = in_instr[19:15];
  assign w_rs2       = in_instr[24:20];
  assign w_funct7    = in_instr[31:25];
  assign w_imm_sext  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign w_imm_shamt = {{(XLEN-5){1'b0}}, in_instr[24:20]};

  regfile #(.XLEN(XLEN)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .i_we      (wb_en),
    .i_waddr   (wb_addr),
    .i_wdata   (wb_data),
    .i_raddr_a (w_rs1),
    .i_raddr_b (w_rs2),
    .o_rdata_a (w_rs1_val),
    .o_rdata_b (w_rs2_val)
  );

  always_comb begin
    w_dec              = '0;
    w_dec.op           = ALU_ADD;
    case (w_opcode)
      OPC_OP: begin
        if (w_funct7 == F7_BASE) begin
          w_dec.legal = 1'b1;
          w_dec.op    = base_op(w_funct3);
        end else if (w_funct7 == F7_ALT) begin
          if (w_funct3 == F3_ADD_SUB) begin
            w_dec.legal = 1'b1;
            w_dec.op    = ALU_SUB;
          end else if (w_funct3 == F3_SRL_SRA) begin
            w_dec.legal = 1'b1;
            w_dec.op    = ALU_SRA;
          end
        end
      end
      OPC_OP_IMM: begin
        w_dec.use_imm = 1'b1;
        // Shift immediates carry funct7 in imm[11:5]; everything else is a plain imm12.
        if (w_funct3 == F3_SLL) begin
          w_dec.imm_is_shamt = 1'b1;
          w_dec.op           = ALU_SLL;
          w_dec.legal        = (w_funct7 == F7_BASE);
        end else if (w_funct3 == F3_SRL_SRA) begin
          w_dec.imm_is_shamt = 1'b1;
          if (w_funct7 == F7_BASE) begin
            w_dec.legal = 1'b1;
            w_dec.op    = ALU_SRL;
          end else if (w_funct7 == F7_ALT) begin
            w_dec.legal = 1'b1;
            w_dec.op    = ALU_SRA;
          end
        end else begin
          w_dec.legal = 1'b1;
          w_dec.op    = base_op(w_funct3);
        end
      end
      default: begin
        w_dec.legal = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_b_sel = w_rs2_val;
    if (w_dec.use_imm) begin
      w_b_sel = w_dec.imm_is_shamt ? w_imm_shamt : w_imm_sext;
    end
  end

  assign in_ready = !flush && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= ALU_ADD;
      r_rd      <= 5'd0;
      r_we      <= 1'b0;
      r_illegal <= 1'b0;
    end else if (flush) begin
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= w_accept && !w_dec.legal;
      if (w_accept) begin
        // An illegal word is consumed but leaves the slot empty.
        r_valid <= w_dec.legal;
        if (w_dec.legal) begin
          r_a  <= w_rs1_val;
          r_b  <= w_b_sel;
          r_op <= w_dec.op;
          r_rd <= w_rd;
          r_we <= (w_rd != 5'd0);
        end
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_a     = r_a;
  assign out_b     = r_b;
  assign out_op    = {{(OPW-4){1'b0}}, r_op};
  assign out_rd    = r_rd;
  assign out_we    = r_we;
  assign illegal   = r_illegal;

endmodule
